// File: rtl/fir_out_requant.sv
// Output requantizer for the transposed-form FIR: drops warm-up samples, rounds and
// saturates each 32-bit result to 16 bits, and buffers it in a show-ahead FIFO.
module fir_out_requant #(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  parameter int DEPTH  = 4,
  parameter int WARMUP = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IN_W-1:0]           yn_in,
  input  logic                      yn_valid,
  output logic [OUT_W-1:0]          yq_out,
  output logic                      yq_valid,
  input  logic                      yq_ready,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      sat_flag,
  output logic                      ovf_flag,
  input  logic                      clr_flags
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WCW-1:0]         WARM_END = WCW'(WARMUP);
  localparam logic signed [IN_W:0]   RND      = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0]   SAT_MAX  = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0]   SAT_MIN  = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [AW:0]            FULL_CNT = (AW+1)'(DEPTH);

  logic [WCW-1:0]   warm_cnt_reg;
  logic             warm_done;
  logic signed [IN_W:0] sum, q;
  logic [OUT_W-1:0] q_sat;
  logic             q_is_sat;

  logic             s1_valid_reg, s1_sat_reg;
  logic [OUT_W-1:0] s1_data_reg;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_next;
  logic [AW:0]      count_reg, count_next;
  logic             full, empty, push, pop, drop, head_from_push;

  assign warm_done = (warm_cnt_reg == WARM_END);

  // Round-half-up in one extra bit of headroom, then arithmetic shift and clamp.
  assign sum = $signed({yn_in[IN_W-1], yn_in}) + RND;
  assign q   = sum >>> SHIFT;

  always_comb begin
    q_sat    = q[OUT_W-1:0];
    q_is_sat = 1'b0;
    if (q > SAT_MAX) begin
      q_sat    = {1'b0, {(OUT_W-1){1'b1}}};
      q_is_sat = 1'b1;
    end else if (q < SAT_MIN) begin
      q_sat    = {1'b1, {(OUT_W-1){1'b0}}};
      q_is_sat = 1'b1;
    end
  end

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_CNT);
  assign pop   = !empty && yq_ready;
  assign push  = s1_valid_reg && (!full || pop);
  assign drop  = s1_valid_reg && full && !pop;
  assign rd_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
  // The head comes straight from stage 1 when the write lands in an otherwise empty FIFO.
  assign head_from_push = push && (empty || (pop && count_reg == (AW+1)'(1)));

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + (AW+1)'(1);
    else if (pop && !push)
      count_next = count_reg - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_cnt_reg <= '0;
      s1_valid_reg <= 1'b0;
      s1_sat_reg   <= 1'b0;
      s1_data_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      yq_out       <= '0;
      sat_flag     <= 1'b0;
      ovf_flag     <= 1'b0;
    end else begin
      if (yn_valid && !warm_done)
        warm_cnt_reg <= warm_cnt_reg + WCW'(1);
      s1_valid_reg <= yn_valid && warm_done;
      s1_sat_reg   <= q_is_sat;
      s1_data_reg  <= q_sat;

      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_next;
      count_reg  <= count_next;
      // Registered head; holds its last value once the FIFO runs empty.
      if (count_next != '0)
        yq_out <= head_from_push ? s1_data_reg : mem[rd_next];

      if (s1_valid_reg && s1_sat_reg)
        sat_flag <= 1'b1;
      else if (clr_flags)
        sat_flag <= 1'b0;
      if (drop)
        ovf_flag <= 1'b1;
      else if (clr_flags)
        ovf_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= s1_data_reg;
  end

  assign yq_valid   = !empty;
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: warm-up, rounding, saturation, FIFO overrun,
// full-FIFO streaming and asynchronous reset.
module tb_fir_out_requant;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] yn_in;
  logic        yn_valid;
  logic [15:0] yq_out;
  logic        yq_valid;
  logic        yq_ready;
  logic [2:0]  fifo_count;
  logic        sat_flag;
  logic        ovf_flag;
  logic        clr_flags;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] got_q [$];

  fir_out_requant dut (
    .clk(clk), .reset(reset), .yn_in(yn_in), .yn_valid(yn_valid),
    .yq_out(yq_out), .yq_valid(yq_valid), .yq_ready(yq_ready),
    .fifo_count(fifo_count), .sat_flag(sat_flag), .ovf_flag(ovf_flag),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  // Record every accepted output at the edge where the handshake completes.
  always @(posedge clk)
    if (!reset && yq_valid && yq_ready) got_q.push_back(yq_out);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic push_sample(input logic [31:0] v);
    yn_in    = v;
    yn_valid = 1'b1;
    @(negedge clk);
    yn_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] e);
    int waitc = 0;
    while (got_q.size() == 0 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (got_q.size() == 0) check({tag, " timeout"}, 32'd0, 32'd1);
    else check(tag, 32'(got_q.pop_front()), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; yn_in = '0; yn_valid = 1'b0; yq_ready = 1'b0; clr_flags = 1'b0;
    #3;
    check("rst yq_valid", 32'(yq_valid), 32'd0);
    check("rst fifo_count", 32'(fifo_count), 32'd0);
    check("rst yq_out", 32'(yq_out), 32'd0);
    check("rst flags", {30'd0, sat_flag, ovf_flag}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Warm-up samples are dropped without touching sat_flag; 6th sample has 2-cycle latency.
    yq_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_sample(32'h7FFF_FFFF);
    push_sample(32'h0000_4000);
    check("lat1 yq_valid", 32'(yq_valid), 32'd0);
    @(negedge clk);
    check("lat2 yq_valid", 32'(yq_valid), 32'd1);
    check("lat2 yq_out", 32'(yq_out), 32'h0001);
    check("warmup sat_flag", 32'(sat_flag), 32'd0);
    @(negedge clk);
    got_q.delete();

    // Rounding around the half-LSB boundary.
    push_sample(32'h0000_3FFF);
    push_sample(32'hFFFF_C000);
    push_sample(32'hFFFF_BFFF);
    push_sample(32'h0000_8000);
    expect_out("rnd 3FFF", 16'h0000);
    expect_out("rnd FFFFC000", 16'h0000);
    expect_out("rnd FFFFBFFF", 16'hFFFF);
    expect_out("rnd 8000", 16'h0001);
    check("rnd sat_flag", 32'(sat_flag), 32'd0);

    // Saturation both ways, then clear.
    push_sample(32'h7FFF_FFFF);
    push_sample(32'h8000_0000);
    expect_out("sat pos", 16'h7FFF);
    expect_out("sat neg", 16'h8000);
    check("sat sat_flag", 32'(sat_flag), 32'd1);
    check("sat ovf_flag", 32'(ovf_flag), 32'd0);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check("clr sat_flag", 32'(sat_flag), 32'd0);

    // Overrun: six samples into a stalled 4-deep FIFO.
    yq_ready = 1'b0;
    for (int k = 1; k <= 6; k++) push_sample(32'(k) << 15);
    repeat (3) @(negedge clk);
    check("ovr fifo_count", 32'(fifo_count), 32'd4);
    check("ovr ovf_flag", 32'(ovf_flag), 32'd1);
    yq_ready = 1'b1;
    for (int k = 1; k <= 4; k++) expect_out($sformatf("ovr out %0d", k), 16'(k));
    repeat (3) @(negedge clk);
    check("ovr lost 5,6", 32'(got_q.size()), 32'd0);
    check("ovr drained", 32'(fifo_count), 32'd0);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check("clr ovf_flag", 32'(ovf_flag), 32'd0);

    // Full FIFO with simultaneous push and pop every cycle: no overrun, order kept.
    yq_ready = 1'b0;
    for (int k = 10; k <= 13; k++) push_sample(32'(k) << 15);
    repeat (2) @(negedge clk);
    check("full fifo_count", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 8; i++) begin
      yn_in    = 32'(14 + i) << 15;
      yn_valid = 1'b1;
      if (i == 1) yq_ready = 1'b1;
      @(negedge clk);
      if (i == 3 || i == 7) check($sformatf("full hold %0d", i), 32'(fifo_count), 32'd4);
    end
    yn_valid = 1'b0;
    for (int k = 10; k <= 21; k++) expect_out($sformatf("full out %0d", k), 16'(k));
    check("full ovf_flag", 32'(ovf_flag), 32'd0);

    // Asynchronous reset mid-stream with three samples buffered.
    yq_ready = 1'b0;
    for (int k = 1; k <= 3; k++) push_sample(32'(k + 30) << 15);
    repeat (2) @(negedge clk);
    check("arst pre count", 32'(fifo_count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("arst yq_valid", 32'(yq_valid), 32'd0);
    check("arst fifo_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    got_q.delete();
    yq_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_sample(32'h7FFF_FFFF);
    repeat (3) @(negedge clk);
    check("rewarm yq_valid", 32'(yq_valid), 32'd0);
    check("rewarm sat_flag", 32'(sat_flag), 32'd0);
    check("rewarm no out", 32'(got_q.size()), 32'd0);
    push_sample(32'd7 << 15);
    expect_out("rewarm first", 16'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
- Reader-side companion to the transposed-form FIR core: consumes the FIR's 32-bit signed output stream, requantizes it to 16-bit signed, and delivers it to a downstream consumer over a valid/ready handshake.
- Drops pipeline warm-up samples after reset, rounds and saturates each sample, and buffers results in a small FIFO so downstream stalls do not stall the filter.
- Sticky flags report saturation and FIFO overrun.

Parameters:
- IN_W, 32, input sample width (FIR yn width)
- OUT_W, 16, output sample width
- SHIFT, 15, right-shift applied before saturation (Q-format scaling); must satisfy 1 <= SHIFT < IN_W
- DEPTH, 4, FIFO depth in samples; power of two, >= 2
- WARMUP, 5, number of valid input samples discarded after reset

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- yn_in  in  IN_W  signed sample from the FIR
- yn_valid  in  1  yn_in is valid this cycle; no backpressure toward the FIR
- yq_out  out  OUT_W  signed requantized sample, head of FIFO
- yq_valid  out  1  FIFO non-empty
- yq_ready  in  1  downstream accepts yq_out when yq_valid is also high
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy
- sat_flag  out  1  sticky: at least one sample was saturated
- ovf_flag  out  1  sticky: at least one sample was dropped because the FIFO was full
- clr_flags  in  1  synchronous clear of sat_flag and ovf_flag

Behaviour:
- Reset (asynchronous, active-high) takes effect immediately:
  - yq_out=0, yq_valid=0, fifo_count=0, sat_flag=0, ovf_flag=0
  - warm-up counter=0; FIFO pointers=0; stage-1 valid=0
  - Reset asserted mid-stream discards all in-flight and buffered samples.
- Warm-up: a counter increments on each yn_valid cycle until it reaches WARMUP. While counter<WARMUP, samples are discarded and affect no flags. With WARMUP=0, no samples are dropped.
- Stage 1 (registered):
  - Sum = sign-extended yn_in (IN_W+1 bits) + 2^(SHIFT-1). This is round-half-up, i.e. ties round toward +inf.
  - q = arithmetic shift right of sum by SHIFT.
  - Saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Register the result together with a sat bit and a valid bit.
- Stage 2: a valid stage-1 result is written to the FIFO tail.
- Latency: yn_valid sampled at edge t gives stage-1 valid after edge t. The FIFO write happens at edge t+1, so with an empty FIFO yq_valid=1 and the data appear after edge t+1 (2 cycles). Throughput is 1 sample/cycle.
- FIFO is show-ahead: yq_out always reflects the head entry. A pop occurs on edge when yq_valid && yq_ready. yq_out is undefined-free and holds its last value when the FIFO is empty.
- Write and pop in the same cycle: both happen and fifo_count is unchanged.
  - This applies when full: a pop frees the slot, so the write is accepted with no overrun.
  - This applies when empty: the pop is not possible, so only the write happens.
- Overrun: write attempted while full without a same-cycle pop. The new sample is dropped, FIFO contents are unchanged, and ovf_flag is set.
- sat_flag is set when a written or dropped sample was saturated. Saturation on an overrun-dropped sample still sets sat_flag.
- Flag set and clr_flags in the same cycle: set wins (flag=1).
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- yq_ready is ignored while yq_valid=0.

Test Plan:
- Reset, then 5 valid samples of 0x7FFFFFFF, then yn_in=0x00004000 with yq_ready=1 -> the 5 samples are dropped and sat_flag stays 0; yq_out=0x0001, yq_valid=1 exactly 2 cycles after the 6th sample.
- After warm-up, inputs 0x00003FFF, 0xFFFFC000, 0xFFFFBFFF, 0x00008000 -> yq_out = 0x0000, 0x0000, 0xFFFF, 0x0001.
- After warm-up, inputs 0x7FFFFFFF then 0x80000000 -> yq_out = 0x7FFF then 0x8000; sat_flag=1. Then clr_flags=1 with no new input -> sat_flag=0.
- yq_ready=0, stream 6 valid post-warm-up samples 1..6 (<<15) -> fifo_count=4, ovf_flag=1. Then yq_ready=1 -> output 1,2,3,4, and 5 and 6 are lost.
- FIFO full with yq_ready=1 and continuous yn_valid -> fifo_count holds at 4, ovf_flag stays 0, output order is preserved.
- Reset asserted asynchronously mid-stream with FIFO at 3 -> yq_valid drops immediately and fifo_count=0. After release, the warm-up restarts and the next 5 samples are dropped.
